// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch and load/store with data priority and a fetch starvation guard
module mem_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 16,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_valid,
   output logic [DW-1:0] f_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_valid,
   output logic [DW-1:0] d_rdata,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic          busy
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t          state_q, state_d;
   logic [3:0]      lat_cnt_q, lat_cnt_d;
   logic [3:0]      starve_cnt_q, starve_cnt_d;
   logic            own_data_q, own_data_d;
   logic            f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
   logic            f_valid_q, f_valid_d, d_valid_q, d_valid_d;
   logic            m_we_q, m_we_d, busy_q, busy_d;
   logic [AW-1:0]   m_addr_q, m_addr_d;
   logic [DW-1:0]   m_wdata_q, m_wdata_d, f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
   logic            fetch_wins;
   if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
      $error("mem_arbiter: RD_LAT must be in 1..15");
   end
   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("mem_arbiter: STARVE_MAX must be in 1..15");
   end
   assign fetch_wins = f_req & (~d_req | (starve_cnt_q == 4'(STARVE_MAX)));
   // next-state: pick a winner in IDLE, count down the RAM latency in BUSY and return data to the owner
   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      own_data_d   = own_data_q;
      f_gnt_d      = 1'b0;
      d_gnt_d      = 1'b0;
      f_valid_d    = 1'b0;
      d_valid_d    = 1'b0;
      m_we_d       = m_we_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      f_rdata_d    = f_rdata_q;
      d_rdata_d    = d_rdata_q;
      busy_d       = busy_q;
      case (state_q)
         IDLE: begin
            busy_d = f_req | d_req;
            if (!f_req) starve_cnt_d = 4'd0;
            if (f_req | d_req) begin
               state_d   = BUSY;
               lat_cnt_d = 4'(RD_LAT - 1);
               if (fetch_wins) begin
                  f_gnt_d      = 1'b1;
                  own_data_d   = 1'b0;
                  m_addr_d     = f_addr;
                  m_we_d       = 1'b0;
                  starve_cnt_d = 4'd0;
               end else begin
                  d_gnt_d    = 1'b1;
                  own_data_d = 1'b1;
                  m_addr_d   = d_addr;
                  m_we_d     = d_we;
                  m_wdata_d  = d_we ? d_wdata : m_wdata_q;
                  if (f_req)
                     starve_cnt_d = (starve_cnt_q == 4'(STARVE_MAX)) ? starve_cnt_q : starve_cnt_q + 4'd1;
               end
            end
         end
         BUSY: begin
            if (lat_cnt_q != 4'd0) begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end else begin
               state_d   = IDLE;
               m_we_d    = 1'b0;
               f_valid_d = ~own_data_q;
               d_valid_d = own_data_q;
               f_rdata_d = own_data_q ? f_rdata_q : m_rdata;
               d_rdata_d = (own_data_q && !m_we_q) ? m_rdata : d_rdata_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state and registered outputs; reset clears everything at once, aborting any access in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         lat_cnt_q    <= 4'd0;
         starve_cnt_q <= 4'd0;
         own_data_q   <= 1'b0;
         f_gnt_q      <= 1'b0;
         d_gnt_q      <= 1'b0;
         f_valid_q    <= 1'b0;
         d_valid_q    <= 1'b0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         f_rdata_q    <= '0;
         d_rdata_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         own_data_q   <= own_data_d;
         f_gnt_q      <= f_gnt_d;
         d_gnt_q      <= d_gnt_d;
         f_valid_q    <= f_valid_d;
         d_valid_q    <= d_valid_d;
         m_we_q       <= m_we_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         f_rdata_q    <= f_rdata_d;
         d_rdata_q    <= d_rdata_d;
         busy_q       <= busy_d;
      end
   end
   assign f_gnt   = f_gnt_q;
   assign d_gnt   = d_gnt_q;
   assign f_valid = f_valid_q;
   assign d_valid = d_valid_q;
   assign f_rdata = f_rdata_q;
   assign d_rdata = d_rdata_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign busy    = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with RD_LAT=1 and RD_LAT=3 instances sharing a RAM model
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [15:0] f_addr = '0, d_addr = '0, d_wdata = '0;
   logic        f_gnt, f_valid, d_gnt, d_valid, m_we, busy;
   logic [15:0] f_rdata, d_rdata, m_addr, m_wdata, m_rdata;
   logic        f_req3 = 1'b0, d_req3 = 1'b0;
   logic [15:0] f_addr3 = '0, d_addr3 = '0;
   logic        f_gnt3, f_valid3, d_gnt3, d_valid3, m_we3, busy3;
   logic [15:0] f_rdata3, d_rdata3, m_addr3, m_wdata3, m_rdata3;
   logic [15:0] ram [0:255];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign m_rdata  = ram[m_addr[7:0]];
   assign m_rdata3 = ram[m_addr3[7:0]];

   always @(posedge clk) if (m_we) ram[m_addr[7:0]] <= m_wdata;

   mem_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u_dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
      .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
   );

   mem_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk(clk), .reset(reset),
      .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_valid(f_valid3), .f_rdata(f_rdata3),
      .d_req(d_req3), .d_we(1'b0), .d_addr(d_addr3), .d_wdata(16'h0000),
      .d_gnt(d_gnt3), .d_valid(d_valid3), .d_rdata(d_rdata3),
      .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3), .busy(busy3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
      ram[4] = 16'hA5C3;
      // 1: reset held with both requests high
      f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0004; d_addr = 16'h0008;
      repeat (3) tick();
      check("rst_f_gnt", f_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_m_we", m_we, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_f_rdata", f_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      f_req = 1'b0; d_req = 1'b0;
      reset = 1'b1;
      tick();
      check("idle_busy", busy, 0);
      tick();
      check("idle_gnt", {f_gnt, d_gnt, f_valid, d_valid}, 0);
      // 2: fetch of RAM[4]
      f_req = 1'b1; f_addr = 16'h0004;
      tick();
      check("f_gnt", f_gnt, 1);
      check("f_m_addr", m_addr, 16'h0004);
      check("f_m_we", m_we, 0);
      check("f_busy_gnt", busy, 1);
      f_req = 1'b0;
      tick();
      check("f_gnt_pulse", f_gnt, 0);
      check("f_valid", f_valid, 1);
      check("f_rdata", f_rdata, 16'hA5C3);
      check("f_busy_valid", busy, 1);
      tick();
      check("f_valid_pulse", f_valid, 0);
      check("f_busy_end", busy, 0);
      // load of RAM[4] so the store can be shown not to touch d_rdata
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0004;
      tick();
      check("ld_gnt", d_gnt, 1);
      d_req = 1'b0;
      tick();
      check("ld_valid", d_valid, 1);
      check("ld_rdata", d_rdata, 16'hA5C3);
      tick();
      // 3: store 0x1234 to 0x0010
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234;
      tick();
      check("st_gnt", d_gnt, 1);
      check("st_m_we", m_we, 1);
      check("st_m_addr", m_addr, 16'h0010);
      check("st_m_wdata", m_wdata, 16'h1234);
      d_req = 1'b0; d_we = 1'b0;
      tick();
      check("st_valid", d_valid, 1);
      check("st_d_rdata_kept", d_rdata, 16'hA5C3);
      tick();
      check("st_m_we_off", m_we, 0);
      check("st_busy_end", busy, 0);
      f_req = 1'b1; f_addr = 16'h0010;
      tick();
      check("rb_gnt", f_gnt, 1);
      f_req = 1'b0;
      tick();
      check("rb_valid", f_valid, 1);
      check("rb_f_rdata", f_rdata, 16'h1234);
      check("rb_d_rdata", d_rdata, 16'hA5C3);
      tick();
      // 4: both requesting continuously, expect D,D,D,D,F repeating, one grant per 2 cycles
      f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = 16'h0004; d_addr = 16'h0010;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i % 2 == 1) begin
            check($sformatf("arb_f_gnt_%0d", i), f_gnt, (((i - 1) / 2) % 5 == 4) ? 1 : 0);
            check($sformatf("arb_d_gnt_%0d", i), d_gnt, (((i - 1) / 2) % 5 == 4) ? 0 : 1);
         end else begin
            check($sformatf("arb_gap_%0d", i), {f_gnt, d_gnt}, 0);
         end
      end
      f_req = 1'b0; d_req = 1'b0;
      repeat (2) tick();
      check("arb_drained", busy, 0);
      // 5: reset in the middle of a store
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'hBEEF;
      tick();
      check("ab_m_we", m_we, 1);
      d_req = 1'b0; d_we = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("ab_m_we_async", m_we, 0);
      check("ab_busy_async", busy, 0);
      check("ab_d_rdata", d_rdata, 0);
      check("ab_f_rdata", f_rdata, 0);
      tick();
      reset = 1'b1;
      tick();
      check("ab_no_valid1", d_valid, 0);
      tick();
      check("ab_no_valid2", d_valid, 0);
      check("ab_busy", busy, 0);
      check("ab_no_write", ram[8'h30], 16'h0000);
      f_req = 1'b1; f_addr = 16'h0004;
      tick();
      check("ab_next_gnt", f_gnt, 1);
      f_req = 1'b0;
      tick();
      check("ab_next_valid", f_valid, 1);
      check("ab_next_rdata", f_rdata, 16'hA5C3);
      tick();
      // 6: RD_LAT=3 load with a fetch pending
      d_req3 = 1'b1; d_addr3 = 16'h0004; f_req3 = 1'b1; f_addr3 = 16'h0010;
      tick();
      check("l3_d_gnt", d_gnt3, 1);
      check("l3_f_not", f_gnt3, 0);
      d_req3 = 1'b0;
      tick();
      check("l3_wait1", {d_valid3, f_gnt3}, 0);
      tick();
      check("l3_wait2", {d_valid3, f_gnt3}, 0);
      tick();
      check("l3_d_valid", d_valid3, 1);
      check("l3_d_rdata", d_rdata3, 16'hA5C3);
      check("l3_f_not_same", f_gnt3, 0);
      tick();
      check("l3_f_gnt", f_gnt3, 1);
      check("l3_d_valid_off", d_valid3, 0);
      f_req3 = 1'b0;
      repeat (2) tick();
      check("l3_f_wait", f_valid3, 0);
      tick();
      check("l3_f_valid", f_valid3, 1);
      check("l3_f_rdata", f_rdata3, 16'h1234);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
